fft_frame_streamer: RTL and testbench

// Source end of the FFT frame stream. Collects real audio samples into

---
 rtl/fft_frame_streamer.sv | 143 ++++++++++++++
 tb/tb_fft_frame_streamer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_streamer.sv
// Ping-pong frame buffer that collects real audio samples and streams each full
// frame as complex words (re = sign-extended sample, im = 0) with valid/ready.
module fft_frame_streamer #(
    parameter int LOG2_N       = 10,
    parameter int SAMPLE_WIDTH = 24
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    output logic [79:0]             fft_data,
    output logic [15:0]             fft_user,
    output logic                    fft_last,
    output logic                    fft_valid,
    input  logic                    fft_ready,
    output logic                    overflow
);

    // Handshake: a word transfers on a rising edge where fft_valid && fft_ready;
    // once raised, fft_valid and the word stay unchanged until that transfer.

    localparam int N     = 1 << LOG2_N;
    localparam int DEPTH = 2 * N;
    localparam logic [LOG2_N-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t state, state_d;

    logic [SAMPLE_WIDTH-1:0]        mem [DEPTH];
    logic signed [SAMPLE_WIDTH-1:0] rd_q;
    logic [1:0]                     bank_full;
    logic                           wr_bank;
    logic [LOG2_N-1:0]              wr_idx;
    logic                           wr_en;
    logic                           rd_bank, rd_bank_d;
    logic [LOG2_N-1:0]              rd_idx, rd_idx_d;
    logic                           rd_en;
    logic                           free_bank;
    logic [LOG2_N:0]                rd_addr;

    // Status is registered, so a bank freed this cycle is not writable until next.
    assign wr_en   = sample_valid && !bank_full[wr_bank];
    assign rd_addr = {rd_bank_d, rd_idx_d};

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[{wr_bank, wr_idx}] <= sample_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bank_full <= 2'b00;
            wr_bank   <= 1'b0;
            wr_idx    <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= sample_valid && bank_full[wr_bank];
            if (free_bank) begin
                bank_full[rd_bank] <= 1'b0;
            end
            if (wr_en) begin
                if (wr_idx == LAST_IDX) begin
                    bank_full[wr_bank] <= 1'b1;
                    wr_bank            <= ~wr_bank;
                    wr_idx             <= '0;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            rd_idx  <= '0;
        end else begin
            state   <= state_d;
            rd_bank <= rd_bank_d;
            rd_idx  <= rd_idx_d;
        end
    end

    // rd_idx is the index of the word currently presented; reads fetch the next one.
    always_comb begin
        state_d   = state;
        rd_bank_d = rd_bank;
        rd_idx_d  = rd_idx;
        rd_en     = 1'b0;
        free_bank = 1'b0;
        case (state)
            IDLE: begin
                if (bank_full[rd_bank]) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                rd_en    = 1'b1;
                rd_idx_d = '0;
                state_d  = STREAM;
            end
            STREAM: begin
                if (fft_ready) begin
                    if (rd_idx == LAST_IDX) begin
                        free_bank = 1'b1;
                        rd_bank_d = ~rd_bank;
                        rd_idx_d  = '0;
                        if (bank_full[~rd_bank]) begin
                            rd_en = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        rd_idx_d = rd_idx + 1'b1;
                        rd_en    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fft_valid = (state == STREAM);
    assign fft_last  = (state == STREAM) && (rd_idx == LAST_IDX);
    assign fft_user  = 16'(rd_idx);
    assign fft_data  = {40'd0, 40'(rd_q)};

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Directed bench for fft_frame_streamer with an 8-word frame (LOG2_N = 3).
module tb_fft_frame_streamer;

    logic        clock;
    logic        reset;
    logic [23:0] sample_in;
    logic        sample_valid;
    logic [79:0] fft_data;
    logic [15:0] fft_user;
    logic        fft_last;
    logic        fft_valid;
    logic        fft_ready;
    logic        overflow;

    int n_checks;
    int n_pass;
    logic [39:0] exp_q[$];

    fft_frame_streamer #(.LOG2_N(3), .SAMPLE_WIDTH(24)) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .fft_data     (fft_data),
        .fft_user     (fft_user),
        .fft_last     (fft_last),
        .fft_valid    (fft_valid),
        .fft_ready    (fft_ready),
        .overflow     (overflow)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic write_frame(input logic [23:0] s[8]);
        for (int i = 0; i < 8; i++) begin
            sample_in    = s[i];
            sample_valid = 1'b1;
            step();
        end
        sample_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int budget;
        budget = 0;
        while (!fft_valid && budget < 10) begin
            step();
            budget++;
        end
        check(tag, 80'(fft_valid), 80'd1);
    endtask

    // Expects 8 consecutive words with fft_ready held high, then fft_valid low.
    task automatic check_frame(input string tag, input logic [39:0] exp[8]);
        fft_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check({tag, "_valid"}, 80'(fft_valid), 80'd1);
            check({tag, "_re"}, 80'(fft_data[39:0]), 80'(exp[k]));
            check({tag, "_im"}, 80'(fft_data[79:40]), 80'd0);
            check({tag, "_user"}, 80'(fft_user), 80'(k));
            check({tag, "_last"}, 80'(fft_last), 80'(k == 7));
            step();
        end
        check({tag, "_end"}, 80'(fft_valid), 80'd0);
    endtask

    initial begin
        logic [23:0] s[8];
        logic [39:0] e[8];
        int budget;
        int idx;
        int cyc;
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        fft_ready    = 1'b0;

        // reset with random inputs: all outputs stay zero
        for (int c = 0; c < 6; c++) begin
            sample_in    = 24'($urandom);
            sample_valid = 1'($urandom_range(0, 1));
            fft_ready    = 1'($urandom_range(0, 1));
            step();
            check("rst_data", fft_data, 80'd0);
            check("rst_user", 80'(fft_user), 80'd0);
            check("rst_last", 80'(fft_last), 80'd0);
            check("rst_valid", 80'(fft_valid), 80'd0);
            check("rst_ovf", 80'(overflow), 80'd0);
        end
        reset        = 1'b0;
        sample_valid = 1'b0;
        fft_ready    = 1'b1;
        step();

        // frame 1..8, ready high, latency of two cycles after sample 8
        for (int i = 0; i < 8; i++) begin
            s[i] = 24'(i + 1);
            e[i] = 40'(i + 1);
        end
        write_frame(s);
        check("lat_c0", 80'(fft_valid), 80'd0);
        step();
        check("lat_c1", 80'(fft_valid), 80'd0);
        step();
        check("lat_c2", 80'(fft_valid), 80'd1);
        check_frame("f1", e);

        // same frame with ready toggling; word held while stalled
        fft_ready = 1'b0;
        write_frame(s);
        wait_valid("tg_wait");
        for (int i = 0; i < 8; i++) exp_q.push_back(40'(i + 1));
        idx = 0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            check("tg_valid", 80'(fft_valid), 80'd1);
            check("tg_re", 80'(fft_data[39:0]), 80'(exp_q[0]));
            check("tg_user", 80'(fft_user), 80'(idx));
            check("tg_last", 80'(fft_last), 80'(idx == 7));
            fft_ready = (cyc % 2 == 0);
            if (fft_valid && fft_ready) begin
                void'(exp_q.pop_front());
                idx++;
            end
            step();
            cyc++;
        end
        check("tg_words_left", 80'(exp_q.size()), 80'd0);
        check("tg_end", 80'(fft_valid), 80'd0);

        // 17 samples with ready low: 16 stored, 17th dropped with overflow pulse
        fft_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            sample_in    = 24'(101 + i);
            sample_valid = 1'b1;
            step();
            check("ovf_pulse", 80'(overflow), 80'(i == 16));
        end
        sample_valid = 1'b0;
        step();
        check("ovf_one_cycle", 80'(overflow), 80'd0);
        fft_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("b2b_valid", 80'(fft_valid), 80'd1);
            check("b2b_re", 80'(fft_data[39:0]), 80'(101 + k));
            check("b2b_user", 80'(fft_user), 80'(k % 8));
            check("b2b_last", 80'(fft_last), 80'(k % 8 == 7));
            step();
        end
        check("b2b_end", 80'(fft_valid), 80'd0);

        // sign extension of extreme values
        s = '{24'h800000, 24'h7FFFFF, 24'hFFFFFF, 24'h000000,
              24'h000001, 24'hC00000, 24'h123456, 24'hABCDEF};
        e = '{40'hFFFF800000, 40'h00007FFFFF, 40'hFFFFFFFFFF, 40'h0000000000,
              40'h0000000001, 40'hFFFFC00000, 40'h0000123456, 40'hFFFFABCDEF};
        write_frame(s);
        wait_valid("sx_wait");
        check_frame("sx", e);

        // reset mid-stream at user 4, then a fresh frame
        for (int i = 0; i < 8; i++) s[i] = 24'(i + 1);
        write_frame(s);
        wait_valid("mr_wait");
        budget = 0;
        while (fft_user != 16'd4 && budget < 10) begin
            step();
            budget++;
        end
        check("mr_reach_user4", 80'(fft_user), 80'd4);
        reset = 1'b1;
        step();
        check("mr_valid_in_rst", 80'(fft_valid), 80'd0);
        check("mr_data_in_rst", fft_data, 80'd0);
        reset = 1'b0;
        step();
        check("mr_valid_after", 80'(fft_valid), 80'd0);
        for (int i = 0; i < 8; i++) begin
            s[i] = 24'(21 + i);
            e[i] = 40'(21 + i);
        end
        write_frame(s);
        wait_valid("mr2_wait");
        check_frame("mr2", e);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
